// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data has priority; a streak counter lets a waiting fetch through after MAX_D_STREAK data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_i,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_streak;
    logic [SW-1:0]     w_streak_next;
    logic              r_i_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_i_elig;
    logic w_d_elig;
    logic w_streak_max;
    logic w_grant_i;
    logic w_grant_d;
    logic w_complete;

    always_comb begin
        w_next        = r_state;
        w_grant_i     = 1'b0;
        w_grant_d     = 1'b0;
        w_complete    = 1'b0;
        w_streak_next = r_streak;
        // A requester whose done is high this cycle sits out one arbitration.
        w_i_elig      = i_req & ~r_i_done;
        w_d_elig      = d_req & ~r_d_done;
        w_streak_max  = (r_streak == SW'(MAX_D_STREAK));

        case (r_state)
            S_IDLE: begin
                if (w_d_elig && !(w_streak_max && w_i_elig)) begin
                    w_grant_d = 1'b1;
                    w_next    = S_BUSY_D;
                end else if (w_i_elig) begin
                    w_grant_i = 1'b1;
                    w_next    = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ack) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        if (w_grant_d) begin
            if (!i_req) begin
                w_streak_next = '0;
            end else if (!w_streak_max) begin
                w_streak_next = r_streak + SW'(1);
            end
        end else if (w_grant_i) begin
            w_streak_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_next;
            r_i_done <= (r_state == S_BUSY_I) && mem_ack;
            r_d_done <= (r_state == S_BUSY_D) && mem_ack;

            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_we ? d_wdata : '0;
            end else if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
            end else if (w_complete) begin
                r_mem_req <= 1'b0;
            end

            if ((r_state == S_BUSY_I) && mem_ack) begin
                r_i_rdata <= mem_rdata;
            end
            // Stores leave the last load result visible.
            if ((r_state == S_BUSY_D) && mem_ack && !r_mem_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_i   = i_req & ~r_i_done;
    assign stall_d   = d_req & ~r_d_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and read data are queued
// by each scenario and consumed by a monitor as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_done, d_done, stall_i, stall_d;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .stall_i(stall_i), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
    } grant_t;

    grant_t        exp_g[$];
    logic [DW-1:0] exp_i[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] mem[logic [AW-1:0]];
    int            tests = 0;
    int            fails = 0;
    bit            mem_auto = 1'b0;
    int            mem_waits = 0;

    // Memory model: acks after mem_waits stall cycles, returns stored word for reads.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (rst_n && mem_req) begin
                    if (cnt == mem_waits) begin
                        mem_ack = 1'b1;
                        cnt     = 0;
                        if (mem_we) begin
                            mem[mem_addr] = mem_wdata;
                            mem_rdata     = $urandom;
                        end else begin
                            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
                        end
                    end else begin
                        mem_ack   = 1'b0;
                        mem_rdata = $urandom;
                        cnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt     = 0;
                end
            end
        end
    end

    // Monitor: grant contents, access length, held outputs, done data, pulse spacing.
    initial begin
        grant_t        cur;
        logic [DW-1:0] e;
        int            len;
        bit            act, prev_cmp, prev_id, prev_dd;
        act = 0; prev_cmp = 0; prev_id = 0; prev_dd = 0; len = 0;
        cur = '{we: 1'b0, addr: '0, wdata: '0, waits: 0};
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                act = 0; prev_cmp = 0; prev_id = 0; prev_dd = 0;
            end else begin
                if (prev_cmp) begin
                    tests++;
                    if (mem_req !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_gap: mem_req=%b expected 0 after completion", mem_req);
                    end
                end
                if (mem_req && !act) begin
                    tests++;
                    if (exp_g.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_grant: addr=%h we=%b expected no grant", mem_addr, mem_we);
                    end else begin
                        cur = exp_g.pop_front();
                        if ({mem_we, mem_addr, mem_wdata} !== {cur.we, cur.addr, cur.wdata}) begin
                            fails++;
                            $display("FAIL grant: we/addr/wdata=%b/%h/%h expected %b/%h/%h",
                                     mem_we, mem_addr, mem_wdata, cur.we, cur.addr, cur.wdata);
                        end
                    end
                    act = 1;
                    len = 0;
                end
                if (mem_req) len++;
                if (mem_req && mem_ack && mem_auto && act) begin
                    tests++;
                    if (len != cur.waits + 1 ||
                        {mem_we, mem_addr, mem_wdata} !== {cur.we, cur.addr, cur.wdata}) begin
                        fails++;
                        $display("FAIL access_hold: len=%0d addr=%h expected len=%0d addr=%h",
                                 len, mem_addr, cur.waits + 1, cur.addr);
                    end
                    act = 0;
                end
                prev_cmp = mem_req && mem_ack;
                if (i_done) begin
                    tests++;
                    if (exp_i.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_i_done: i_rdata=%h expected no done", i_rdata);
                    end else begin
                        e = exp_i.pop_front();
                        if (i_rdata !== e) begin
                            fails++;
                            $display("FAIL i_rdata: got %h expected %h", i_rdata, e);
                        end
                    end
                end
                if (d_done) begin
                    tests++;
                    if (exp_d.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_d_done: d_rdata=%h expected no done", d_rdata);
                    end else begin
                        e = exp_d.pop_front();
                        if (d_rdata !== e) begin
                            fails++;
                            $display("FAIL d_rdata: got %h expected %h", d_rdata, e);
                        end
                    end
                end
                if (prev_id || prev_dd) begin
                    tests++;
                    if ((prev_id && i_done) || (prev_dd && d_done)) begin
                        fails++;
                        $display("FAIL done_twice: i_done=%b d_done=%b expected single-cycle pulses", i_done, d_done);
                    end
                end
                prev_id = i_done;
                prev_dd = d_done;
            end
        end
    end

    task automatic do_fetch(input logic [AW-1:0] a, output int cyc);
        i_addr = a;
        i_req  = 1'b1;
        cyc    = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!i_done && cyc < 100);
        tests++;
        if (!i_done) begin
            fails++;
            $display("FAIL fetch_timeout: i_done=%b expected 1 within 100 cycles", i_done);
        end
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int cyc);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        cyc     = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!d_done && cyc < 100);
        tests++;
        if (!d_done) begin
            fails++;
            $display("FAIL data_timeout: d_done=%b expected 1 within 100 cycles", d_done);
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        mem_auto = 1'b0;
        rst_n    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            #1;
            tests++;
            if ({mem_req, mem_we, i_done, d_done, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: req/we/id/dd=%b%b%b%b addr=%h wdata=%h ir=%h dr=%h expected all 0",
                         mem_req, mem_we, i_done, d_done, mem_addr, mem_wdata, i_rdata, d_rdata);
            end
        end
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (mem_req !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle: mem_req=%b expected 0", mem_req);
            end
        end
        mem_auto = 1'b1;
    endtask

    task automatic test_single_fetch();
        mem_waits = 0;
        mem[32'h0040_0000] = 32'h2402_000A;
        exp_g.push_back('{we: 1'b0, addr: 32'h0040_0000, wdata: '0, waits: 0});
        exp_i.push_back(32'h2402_000A);
        @(negedge clk);
        i_addr = 32'h0040_0000;
        i_req  = 1'b1;
        #1;
        tests++;
        if (stall_i !== 1'b1) begin fails++; $display("FAIL fetch_stall_c0: stall_i=%b expected 1", stall_i); end
        @(negedge clk);
        #1;
        tests++;
        if ({mem_req, mem_we, mem_addr, stall_i} !== {1'b1, 1'b0, 32'h0040_0000, 1'b1}) begin
            fails++;
            $display("FAIL fetch_c1: req/we/addr/stall=%b/%b/%h/%b expected 1/0/00400000/1",
                     mem_req, mem_we, mem_addr, stall_i);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({i_done, i_rdata, stall_i, mem_req} !== {1'b1, 32'h2402_000A, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fetch_c2: done/rdata/stall/req=%b/%h/%b/%b expected 1/2402000a/0/0",
                     i_done, i_rdata, stall_i, mem_req);
        end
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (exp_g.size() + exp_i.size() + exp_d.size() != 0) begin
            fails++;
            $display("FAIL fetch_drain: pending=%0d expected 0", exp_g.size() + exp_i.size() + exp_d.size());
        end
    endtask

    task automatic test_store_load();
        int c;
        mem_waits = 2;
        mem[32'h1001_0004] = 32'h1234_5678;
        exp_g.push_back('{we: 1'b0, addr: 32'h1001_0004, wdata: '0, waits: 2});
        exp_g.push_back('{we: 1'b1, addr: 32'h1001_0000, wdata: 32'hDEAD_BEEF, waits: 2});
        exp_g.push_back('{we: 1'b0, addr: 32'h1001_0000, wdata: '0, waits: 2});
        exp_d.push_back(32'h1234_5678);
        exp_d.push_back(32'h1234_5678);
        exp_d.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        do_data(1'b0, 32'h1001_0004, 32'hFFFF_FFFF, c);
        tests++;
        if (c != 4) begin fails++; $display("FAIL load_latency: cycles=%0d expected 4", c); end
        do_data(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, c);
        tests++;
        if (c != 5) begin fails++; $display("FAIL store_latency: cycles=%0d expected 5", c); end
        do_data(1'b0, 32'h1001_0000, 32'h0, c);
        repeat (2) @(negedge clk);
        tests++;
        if (exp_g.size() + exp_i.size() + exp_d.size() != 0) begin
            fails++;
            $display("FAIL store_load_drain: pending=%0d expected 0", exp_g.size() + exp_i.size() + exp_d.size());
        end
    endtask

    task automatic test_contention();
        int cd, cf;
        mem_waits = 0;
        mem[32'h1001_0008] = 32'hCAFE_0008;
        mem[32'h0040_0004] = 32'h0000_0004;
        exp_g.push_back('{we: 1'b0, addr: 32'h1001_0008, wdata: '0, waits: 0});
        exp_g.push_back('{we: 1'b0, addr: 32'h0040_0004, wdata: '0, waits: 0});
        exp_d.push_back(32'hCAFE_0008);
        exp_i.push_back(32'h0000_0004);
        @(negedge clk);
        fork
            do_data(1'b0, 32'h1001_0008, 32'h0, cd);
            do_fetch(32'h0040_0004, cf);
        join
        tests++;
        if (cd != 2 || cf != 4) begin
            fails++;
            $display("FAIL contention_order: data=%0d fetch=%0d cycles expected 2 and 4", cd, cf);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (exp_g.size() + exp_i.size() + exp_d.size() != 0) begin
            fails++;
            $display("FAIL contention_drain: pending=%0d expected 0", exp_g.size() + exp_i.size() + exp_d.size());
        end
    endtask

    // The fetcher backs off during d_done cycles so that every data grant sees i_req=1
    // while the fetch never wins by default; only the streak limit lets it through.
    task automatic test_streak();
        int nd, ni, n;
        logic [AW-1:0] base, a;
        mem_waits = 0;
        base = 32'h1002_0000;
        for (int k = 0; k < 8; k++) begin
            a = base + AW'(4 * k);
            mem[a] = a ^ 32'hA5A5_0000;
        end
        mem[32'h0040_0100] = 32'h1111_0100;
        mem[32'h0040_0200] = 32'h2222_0200;
        for (int k = 0; k < 8; k++) begin
            a = base + AW'(4 * k);
            exp_g.push_back('{we: 1'b0, addr: a, wdata: '0, waits: 0});
            exp_d.push_back(a ^ 32'hA5A5_0000);
            if (k == 3) exp_g.push_back('{we: 1'b0, addr: 32'h0040_0100, wdata: '0, waits: 0});
            if (k == 7) exp_g.push_back('{we: 1'b0, addr: 32'h0040_0200, wdata: '0, waits: 0});
        end
        exp_i.push_back(32'h1111_0100);
        exp_i.push_back(32'h2222_0200);
        nd = 0; ni = 0; n = 0;
        @(negedge clk);
        d_we = 1'b0; d_addr = base; d_req = 1'b1;
        i_addr = 32'h0040_0100; i_req = 1'b1;
        while ((nd < 8 || ni < 2) && n < 300) begin
            @(negedge clk);
            n++;
            if (d_done) begin nd++; d_addr = base + AW'(4 * nd); end
            if (i_done) begin ni++; i_addr = 32'h0040_0200; end
            if (nd >= 8 && ni >= 2) begin
                d_req = 1'b0; i_req = 1'b0;
            end else begin
                d_req = 1'b1; i_req = !d_done;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        tests++;
        if (nd != 8 || ni != 2) begin
            fails++;
            $display("FAIL streak_timeout: data=%0d fetch=%0d completions expected 8 and 2", nd, ni);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (exp_g.size() + exp_i.size() + exp_d.size() != 0) begin
            fails++;
            $display("FAIL streak_drain: pending=%0d expected 0", exp_g.size() + exp_i.size() + exp_d.size());
        end
    endtask

    task automatic test_idle_ack();
        mem_auto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            @(negedge clk);
            #1;
            tests++;
            if ({mem_req, i_done, d_done, i_rdata, d_rdata} !==
                {1'b0, 1'b0, 1'b0, 32'h2222_0200, 32'h1002_001C ^ 32'hA5A5_0000}) begin
                fails++;
                $display("FAIL idle_ack: req/id/dd=%b%b%b ir=%h dr=%h expected 000 22220200 b5a7001c",
                         mem_req, i_done, d_done, i_rdata, d_rdata);
            end
        end
        mem_ack  = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        int n;
        mem_auto  = 1'b0;
        mem_waits = 1;
        mem[32'h1001_0020] = 32'h0BAD_F00D;
        exp_g.push_back('{we: 1'b0, addr: 32'h1001_0020, wdata: '0, waits: 1});
        @(negedge clk);
        d_we = 1'b0; d_addr = 32'h1001_0020; d_req = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: mem_req=%b expected 1", mem_req); end
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_req: mem_req=%b expected 0", mem_req); end
        @(negedge clk);
        #1;
        tests++;
        if ({d_done, d_rdata, i_rdata} !== {1'b0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL rst_mid_done: d_done=%b d_rdata=%h i_rdata=%h expected 0/0/0", d_done, d_rdata, i_rdata);
        end
        mem_ack = 1'b0;
        exp_g.push_back('{we: 1'b0, addr: 32'h1001_0020, wdata: '0, waits: 1});
        exp_d.push_back(32'h0BAD_F00D);
        mem_auto = 1'b1;
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_done && n < 20);
        tests++;
        if (!d_done) begin fails++; $display("FAIL rst_mid_retry: d_done=%b expected 1", d_done); end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (exp_g.size() + exp_i.size() + exp_d.size() != 0) begin
            fails++;
            $display("FAIL rst_mid_drain: pending=%0d expected 0", exp_g.size() + exp_i.size() + exp_d.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        rst_n = 1'b0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_streak();
        test_idle_ack();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
